// File: rtl/rbe_accumulators_readout_pkg.sv
// Shared types and defaults for the RBE accumulator readout sequencer.
// The beat struct is sized by the package widths, so the top-level width parameters must keep them.
package rbe_package;

  localparam int RBE_DATA_WIDTH         = 32;
  localparam int RBE_WIDTH_FACTOR       = 4;
  localparam int RBE_READOUT_FIFO_DEPTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_CLEAR,
    ST_DONE
  } readout_state_e;

  typedef struct packed {
    logic [RBE_WIDTH_FACTOR*RBE_DATA_WIDTH-1:0] data;
    logic [RBE_WIDTH_FACTOR-1:0]                strb;
    logic                                       last;
  } readout_beat_t;

endpackage

// File: rtl/rbe_accumulators_readout_fifo.sv
// Small synchronous FIFO of readout beats with occupancy output.
// Supports a push and a pop in the same cycle even when full.
module rbe_readout_fifo
  import rbe_package::*;
#(
  parameter int DEPTH = RBE_READOUT_FIFO_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  readout_beat_t                data_i,
  input  logic                         pop_i,
  output readout_beat_t                data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  readout_beat_t   r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o     = (r_count == '0);
  assign full_o      = (r_count == CW'(DEPTH));
  assign occupancy_o = r_count;
  assign data_o      = r_mem[r_rptr];

  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rbe_accumulators_readout.sv
// Read-side sequencer for the RBE accumulator bank: issues credit-limited reads, buffers the
// registered read data and streams it out, optionally clearing the bank once drained.
//   state | meaning
//   IDLE  | waiting for start_i
//   READ  | issuing reads while FIFO credit allows
//   DRAIN | last read issued, waiting for FIFO empty and nothing in flight
//   CLEAR | one-cycle bank clear
//   DONE  | one-cycle done pulse
module rbe_accumulators_readout
  import rbe_package::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = RBE_DATA_WIDTH,
  parameter int NUM_WORDS    = 2**ADDR_WIDTH,
  parameter int WIDTH_FACTOR = RBE_WIDTH_FACTOR,
  parameter int FIFO_DEPTH   = RBE_READOUT_FIFO_DEPTH
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic                               wide_i,
  input  logic [ADDR_WIDTH-1:0]              base_addr_i,
  input  logic [ADDR_WIDTH:0]                nb_words_i,
  input  logic                               clear_after_i,
  output logic                               acc_re_o,
  output logic [ADDR_WIDTH-1:0]              acc_raddr_o,
  output logic                               acc_wide_enable_o,
  output logic                               acc_clear_o,
  input  logic [WIDTH_FACTOR*DATA_WIDTH-1:0] acc_rdata_wide_i,
  output logic [WIDTH_FACTOR*DATA_WIDTH-1:0] data_o,
  output logic [WIDTH_FACTOR-1:0]            strb_o,
  output logic                               last_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int BW    = WIDTH_FACTOR * DATA_WIDTH;

  readout_state_e            r_state;
  readout_state_e            w_state_next;
  logic                      r_wide;
  logic                      r_clear_after;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [CNT_W-1:0]          r_beats_left;
  logic [CNT_W-1:0]          r_words_left;
  logic                      r_inflight;
  logic [WIDTH_FACTOR-1:0]   r_if_strb;
  logic                      r_if_last;

  logic [CNT_W-1:0]          w_nb;
  logic [CNT_W:0]            w_nb_round;
  logic [CNT_W-1:0]          w_beats;
  logic [CNT_W-1:0]          w_step_words;
  logic [WIDTH_FACTOR-1:0]   w_issue_strb;
  logic                      w_start;
  logic                      w_credit;
  logic                      w_issue;
  logic                      w_final_issue;
  logic                      w_empty;
  logic                      w_full;
  logic [OCC_W-1:0]          w_occ;
  readout_beat_t             w_push_beat;
  readout_beat_t             w_head;

  assign w_nb       = (nb_words_i > CNT_W'(NUM_WORDS)) ? CNT_W'(NUM_WORDS) : nb_words_i;
  assign w_nb_round = ({1'b0, w_nb} + (CNT_W+1)'(WIDTH_FACTOR - 1)) / (CNT_W+1)'(WIDTH_FACTOR);
  assign w_beats    = wide_i ? w_nb_round[CNT_W-1:0] : w_nb;
  assign w_start    = (r_state == ST_IDLE) && start_i;

  // Occupancy is taken before any same-cycle pop, so the credit check is conservative.
  assign w_credit = !w_full &&
                    (((OCC_W+1)'(w_occ) + (OCC_W+1)'(r_inflight)) < (OCC_W+1)'(FIFO_DEPTH));
  assign w_issue       = (r_state == ST_READ) && w_credit;
  assign w_final_issue = w_issue && (r_beats_left == CNT_W'(1));

  assign w_step_words = r_wide ? ((r_words_left > CNT_W'(WIDTH_FACTOR)) ? CNT_W'(WIDTH_FACTOR)
                                                                        : r_words_left)
                               : CNT_W'(1);

  always_comb begin
    w_issue_strb = '0;
    for (int i = 0; i < WIDTH_FACTOR; i++) begin
      w_issue_strb[i] = r_wide ? (r_words_left > CNT_W'(i)) : (i == 0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    acc_re_o     = 1'b0;
    acc_clear_o  = 1'b0;
    done_o       = 1'b0;
    busy_o       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_state_next = (w_nb == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        acc_re_o = w_issue;
        if (w_final_issue) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_empty && !r_inflight) w_state_next = r_clear_after ? ST_CLEAR : ST_DONE;
      end
      ST_CLEAR: begin
        acc_clear_o  = 1'b1;
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done_o       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wide        <= 1'b0;
      r_clear_after <= 1'b0;
      r_addr        <= '0;
      r_beats_left  <= '0;
      r_words_left  <= '0;
      r_inflight    <= 1'b0;
      r_if_strb     <= '0;
      r_if_last     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_if_strb  <= w_issue_strb;
      r_if_last  <= w_final_issue;
      if (w_start) begin
        r_wide        <= wide_i;
        r_clear_after <= clear_after_i;
        r_addr        <= base_addr_i;
        r_beats_left  <= w_beats;
        r_words_left  <= w_nb;
      end else if (w_issue) begin
        r_addr       <= r_addr + (r_wide ? ADDR_WIDTH'(WIDTH_FACTOR) : ADDR_WIDTH'(1));
        r_beats_left <= r_beats_left - CNT_W'(1);
        r_words_left <= r_words_left - w_step_words;
      end
    end
  end

  // Narrow reads only trust lane 0 of the bank output; upper lanes are zeroed.
  always_comb begin
    w_push_beat.data = r_wide ? acc_rdata_wide_i : BW'(acc_rdata_wide_i[DATA_WIDTH-1:0]);
    w_push_beat.strb = r_if_strb;
    w_push_beat.last = r_if_last;
  end

  rbe_readout_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (r_inflight),
    .data_i      (w_push_beat),
    .pop_i       (valid_o && ready_i),
    .data_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .occupancy_o (w_occ)
  );

  assign valid_o           = !w_empty;
  assign data_o            = valid_o ? w_head.data : '0;
  assign strb_o            = valid_o ? w_head.strb : '0;
  assign last_o            = valid_o && w_head.last;
  assign acc_raddr_o       = r_addr;
  assign acc_wide_enable_o = r_wide && busy_o;

endmodule

// File: tb/tb_rbe_accumulators_readout.sv
// Self-checking bench for rbe_accumulators_readout: bank model, directed and randomized jobs
// compared against an expected beat list built from the job parameters.
module tb_rbe_accumulators_readout;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int WF = 4;
  localparam int NW = 32;
  localparam int FD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, start, wide, clr_after, ready;
  logic [AW-1:0]   base;
  logic [AW:0]     nb;
  logic            acc_re, acc_wide_en, acc_clear;
  logic [AW-1:0]   acc_raddr;
  logic [WF*DW-1:0] rdata, dout;
  logic [WF-1:0]   strb;
  logic            last, valid, busy, done;

  logic [DW-1:0]   mem [NW];
  int              n_tests = 0;
  int              n_fail  = 0;

  typedef struct packed {
    logic [WF*DW-1:0] d;
    logic [WF-1:0]    s;
    logic             l;
  } tb_beat_t;

  tb_beat_t exp_q[$];
  int       addr_q[$];

  rbe_accumulators_readout dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .start_i           (start),
    .wide_i            (wide),
    .base_addr_i       (base),
    .nb_words_i        (nb),
    .clear_after_i     (clr_after),
    .acc_re_o          (acc_re),
    .acc_raddr_o       (acc_raddr),
    .acc_wide_enable_o (acc_wide_en),
    .acc_clear_o       (acc_clear),
    .acc_rdata_wide_i  (rdata),
    .data_o            (dout),
    .strb_o            (strb),
    .last_o            (last),
    .valid_o           (valid),
    .ready_i           (ready),
    .busy_o            (busy),
    .done_o            (done)
  );

  // Bank: registered read of WF consecutive words (wrapping), clear zeroes the read register.
  always @(posedge clk) begin
    if (acc_clear) rdata <= '0;
    else if (acc_re)
      for (int i = 0; i < WF; i++) rdata[i*DW +: DW] <= mem[(int'(acc_raddr) + i) % NW];
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic init_mem(input bit seq);
    for (int k = 0; k < NW; k++) mem[k] = seq ? 32'(k + 100) : $urandom;
  endtask

  task automatic build_model(input bit w, input int b, input int n);
    int nc, beats, step;
    exp_q.delete();
    addr_q.delete();
    nc    = (n > NW) ? NW : n;
    step  = w ? WF : 1;
    beats = w ? (nc + WF - 1) / WF : nc;
    for (int k = 0; k < beats; k++) begin
      tb_beat_t bt;
      int a0, rem;
      a0  = (b + k * step) % NW;
      rem = nc - k * WF;
      bt  = '0;
      if (w) begin
        for (int i = 0; i < WF; i++) begin
          bt.d[i*DW +: DW] = mem[(a0 + i) % NW];
          bt.s[i]          = (i < rem);
        end
      end else begin
        bt.d[DW-1:0] = mem[a0];
        bt.s[0]      = 1'b1;
      end
      bt.l = (k == beats - 1);
      exp_q.push_back(bt);
      addr_q.push_back(a0);
    end
  endtask

  // stall > 0: ready low for that many cycles after first valid; stall < 0: random ready.
  task automatic run_job(input bit seq, input bit w, input int b, input int n, input bit c,
                         input int stall, input int spur, output int done_cyc);
    int dones, clears, outst, max_out, stall_left, post, cyc, ea;
    bit stall_begun, overlap, held_v, done_seen;
    tb_beat_t held, got;
    init_mem(seq);
    build_model(w, b, n);
    dones = 0; clears = 0; outst = 0; max_out = 0; stall_left = 0; post = 0; cyc = 0;
    stall_begun = 0; overlap = 0; held_v = 0; done_seen = 0; held = '0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1; wide = w; base = AW'(b); nb = (AW+1)'(n); clr_after = c; ready = 1'b1;
    while (cyc < 400 && post < 3) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == spur) begin
        start = 1'b1; wide = !w; base = AW'($urandom); nb = (AW+1)'(5); clr_after = !c;
      end
      if (done_seen) post++;
      got = {dout, strb, last};
      if (held_v) check("hold_stable", 160'({valid, got}), 160'({1'b1, held}));
      if (acc_re) begin
        ea = (addr_q.size() > 0) ? addr_q.pop_front() : -1;
        check("read_addr", 160'(acc_raddr), 160'(ea));
        check("wide_en", 160'(acc_wide_en), 160'(w));
      end
      if (acc_clear) begin
        clears++;
        if (acc_re) overlap = 1'b1;
      end
      if (done) begin
        dones++;
        if (!done_seen) begin
          done_cyc = cyc;
          check("clear_before_done", 160'(clears), 160'(c));
        end
        done_seen = 1'b1;
      end
      if (stall > 0 && !stall_begun && valid) begin
        stall_begun = 1'b1;
        stall_left  = stall;
      end
      if (stall < 0) ready = 1'($urandom_range(0, 1));
      else if (stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end else ready = 1'b1;
      if (valid && ready) begin
        if (exp_q.size() > 0) check("beat", 160'(got), 160'(exp_q.pop_front()));
        else                  check("extra_beat", 160'(valid), 160'(0));
      end
      outst = outst + int'(acc_re) - int'(valid && ready);
      if (outst > max_out) max_out = outst;
      held_v = valid && !ready;
      held   = got;
    end
    ready = 1'b1;
    check("beats_missing", 160'(exp_q.size()), 160'(0));
    check("reads_missing", 160'(addr_q.size()), 160'(0));
    check("done_count", 160'(dones), 160'(1));
    check("clear_count", 160'(clears), 160'(c));
    check("clear_re_overlap", 160'(overlap), 160'(0));
    check("max_outstanding_ok", 160'(max_out <= FD), 160'(1));
    check("idle_after_done", 160'(busy), 160'(0));
  endtask

  initial begin
    int dc, quiet;
    rst_n = 1'b0; start = 1'b0; wide = 1'b0; base = '0; nb = '0; clr_after = 1'b0; ready = 1'b0;
    init_mem(1'b1);
    repeat (3) @(negedge clk);
    check("reset_outputs",
          160'({acc_re, acc_raddr, acc_wide_en, acc_clear, dout, strb, last, valid, busy, done}),
          160'(0));
    rst_n = 1'b1;

    run_job(1'b1, 1'b0, 0, 5, 1'b0, 0, -1, dc);
    run_job(1'b0, 1'b1, 28, 8, 1'b1, 0, -1, dc);
    run_job(1'b0, 1'b1, 10, 6, 1'b0, 0, -1, dc);
    run_job(1'b0, 1'b0, 7, 8, 1'b0, 10, 3, dc);
    run_job(1'b0, 1'b0, 4, 0, 1'b0, 0, 1, dc);
    check("nb0_done_latency", 160'(dc >= 1 && dc <= 2), 160'(1));

    // Reset while draining a full FIFO with backpressure.
    init_mem(1'b0);
    @(negedge clk);
    start = 1'b1; wide = 1'b0; base = AW'(3); nb = (AW+1)'(2); clr_after = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("drain_pending", 160'({busy, valid, acc_re}), 160'(3'b110));
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_drain",
          160'({acc_re, acc_raddr, acc_wide_en, acc_clear, dout, strb, last, valid, busy, done}),
          160'(0));
    rst_n = 1'b1;
    ready = 1'b1;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      quiet += int'(done) + int'(acc_clear) + int'(valid) + int'(acc_re) + int'(busy);
    end
    check("post_reset_quiet", 160'(quiet), 160'(0));
    run_job(1'b0, 1'b1, 30, 13, 1'b1, -1, -1, dc);

    run_job(1'b0, 1'b0, 17, 40, 1'b0, -1, -1, dc);
    run_job(1'b0, 1'b1, 5, 45, 1'b1, 0, -1, dc);
    for (int j = 0; j < 6; j++) begin
      run_job(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
              int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)),
              (j % 2 == 0) ? -1 : 0, -1, dc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
